// File: rtl/cam_capture_ctrl.sv
// Camera capture controller: arms on request, gates frames into data_vld.
// Optional internal test-pattern source built when CAM_TEST_PATTERN_EN is defined.
module cam_capture_ctrl #(
    parameter int PIX_W    = 12,
    parameter int PPC      = 2,
    parameter int CNT_W    = 16,
    parameter int LINE_GAP = 256
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   frame_valid_in,
    input  logic                   new_frame_in,
    input  logic                   pixel_vld_in,
    input  logic [PIX_W*PPC-1:0]   pixel_in,
    input  logic [CNT_W-1:0]       image_width,
    input  logic [CNT_W-1:0]       image_height,
    input  logic [7:0]             frame_count,
    input  logic                   capture,
    input  logic                   abort,
    input  logic                   test_mode,
    output logic                   new_frame,
    output logic [PIX_W*PPC-1:0]   pixel,
    output logic                   data_vld,
    output logic                   busy,
    output logic                   capture_end,
    output logic [7:0]             frames_done
);

    localparam int BW = PIX_W * PPC;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GAP,
        ARMED,
        CAPTURE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] col_q, line_q;
    logic [CNT_W-1:0] col_max, line_max;
    logic [7:0]       cnt_q;

    logic             src_nf, src_fv, src_vld;
    logic [BW-1:0]    src_pix;

    logic start, clr, done_inc, end_d, last_beat, more;

    assign col_max  = image_width - CNT_W'(PPC);
    assign line_max = image_height - CNT_W'(1);

`ifdef CAM_TEST_PATTERN_EN
    localparam int GAP_W = $clog2(LINE_GAP + 1);

    typedef enum logic [1:0] {
        G_IDLE,
        G_SOF,
        G_GAP,
        G_LINE
    } gen_t;

    gen_t             gen_q, gen_d;
    logic [CNT_W-1:0] gcol_q, gcol_d, gline_q, gline_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [BW-1:0]    tp_pix;

    // Generator state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gen_q   <= G_IDLE;
            gcol_q  <= '0;
            gline_q <= '0;
            gcnt_q  <= '0;
        end else begin
            gen_q   <= gen_d;
            gcol_q  <= gcol_d;
            gline_q <= gline_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Generator sequencing: SOF pulse, then gap + line per image line.
    always_comb begin
        gen_d   = gen_q;
        gcol_d  = gcol_q;
        gline_d = gline_q;
        gcnt_d  = gcnt_q;
        case (gen_q)
            G_IDLE: begin
                if (state_q == ARMED) gen_d = G_SOF;
            end
            G_SOF: begin
                gen_d   = G_GAP;
                gcnt_d  = '0;
                gline_d = '0;
                gcol_d  = '0;
            end
            G_GAP: begin
                if (gcnt_q == GAP_W'(LINE_GAP - 1)) gen_d = G_LINE;
                else gcnt_d = gcnt_q + GAP_W'(1);
            end
            G_LINE: begin
                if (gcol_q == col_max) begin
                    gcol_d = '0;
                    gcnt_d = '0;
                    if (gline_q == line_max) begin
                        gen_d = G_IDLE;
                    end else begin
                        gline_d = gline_q + CNT_W'(1);
                        gen_d   = G_GAP;
                    end
                end else begin
                    gcol_d = gcol_q + CNT_W'(PPC);
                end
            end
            default: gen_d = G_IDLE;
        endcase
        // Leaving test mode or dropping the request stops the pattern.
        if (!test_mode || state_q == IDLE) gen_d = G_IDLE;
    end

    // Pattern pixel k = line + column + k, wrapping at the pixel width.
    always_comb begin
        tp_pix = '0;
        for (int k = 0; k < PPC; k++) begin
            tp_pix[k*PIX_W +: PIX_W] = PIX_W'(gline_q) + PIX_W'(gcol_q)
                                     + PIX_W'(k);
        end
    end

    // Source select between camera and pattern.
    always_comb begin
        src_nf  = new_frame_in;
        src_fv  = frame_valid_in;
        src_vld = pixel_vld_in;
        src_pix = pixel_in;
        if (test_mode) begin
            src_nf  = (gen_q == G_SOF);
            src_fv  = (gen_q == G_GAP) || (gen_q == G_LINE);
            src_vld = (gen_q == G_LINE);
            src_pix = tp_pix;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;

    assign src_nf  = new_frame_in;
    assign src_fv  = frame_valid_in;
    assign src_vld = pixel_vld_in;
    assign src_pix = pixel_in;
`endif

    assign new_frame = src_nf;
    assign pixel     = src_pix;
    assign data_vld  = src_vld && (state_q == CAPTURE);
    assign busy      = (state_q != IDLE);

    assign last_beat = data_vld && (col_q == col_max) && (line_q == line_max);
    assign more      = ({1'b0, frames_done} + 9'd1) < {1'b0, cnt_q};

    // Capture FSM next-state and control strobes.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        clr      = 1'b0;
        done_inc = 1'b0;
        end_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    start   = 1'b1;
                    state_d = src_fv ? WAIT_GAP : ARMED;
                end
            end
            WAIT_GAP: begin
                if (!src_fv) state_d = ARMED;
            end
            ARMED: begin
                if (src_nf) begin
                    clr     = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (src_nf) begin
                    clr = 1'b1;
                end else if (last_beat) begin
                    done_inc = 1'b1;
                    if (more) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                        end_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Cancel overrides everything, including start and completion.
        if (abort) begin
            state_d  = IDLE;
            start    = 1'b0;
            done_inc = 1'b0;
            end_d    = 1'b0;
        end
    end

    // State, counters, frame tally and completion pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            line_q      <= '0;
            cnt_q       <= '0;
            frames_done <= '0;
            capture_end <= 1'b0;
        end else begin
            state_q     <= state_d;
            capture_end <= end_d;
            if (start) begin
                frames_done <= '0;
                cnt_q       <= (frame_count == 8'd0) ? 8'd1 : frame_count;
            end else if (done_inc && frames_done != 8'hFF) begin
                frames_done <= frames_done + 8'd1;
            end
            if (start || clr) begin
                col_q  <= '0;
                line_q <= '0;
            end else if (data_vld) begin
                if (col_q == col_max) begin
                    col_q  <= '0;
                    line_q <= (line_q == line_max) ? '0 : line_q + CNT_W'(1);
                end else begin
                    col_q <= col_q + CNT_W'(PPC);
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed self-checking bench for cam_capture_ctrl.
module tb_cam_capture_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        frame_valid_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic        pixel_vld_in = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [15:0] image_width = 16'd8;
    logic [15:0] image_height = 16'd2;
    logic [7:0]  frame_count = 8'd1;
    logic        capture = 1'b0;
    logic        abort = 1'b0;
    logic        test_mode = 1'b0;
    logic        new_frame;
    logic [23:0] pixel;
    logic        data_vld;
    logic        busy;
    logic        capture_end;
    logic [7:0]  frames_done;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int vld_cnt = 0;
    int end_cnt = 0;
    int end_cyc = 0;
    int nf_cyc = 0;
    int pix_err = 0;
    logic [23:0] vpix [64];
    int          vcyc [64];

    cam_capture_ctrl #(
        .PIX_W(12), .PPC(2), .CNT_W(16), .LINE_GAP(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .frame_valid_in(frame_valid_in), .new_frame_in(new_frame_in),
        .pixel_vld_in(pixel_vld_in), .pixel_in(pixel_in),
        .image_width(image_width), .image_height(image_height),
        .frame_count(frame_count), .capture(capture), .abort(abort),
        .test_mode(test_mode), .new_frame(new_frame), .pixel(pixel),
        .data_vld(data_vld), .busy(busy), .capture_end(capture_end),
        .frames_done(frames_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Mid-cycle monitor: inputs move just after rising edges.
    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (data_vld) begin
            vpix[vld_cnt % 64] <= pixel;
            vcyc[vld_cnt % 64] <= cyc;
            vld_cnt <= vld_cnt + 1;
            if (!test_mode && pixel !== pixel_in) pix_err <= pix_err + 1;
        end
        if (capture_end) begin
            end_cnt <= end_cnt + 1;
            end_cyc <= cyc;
        end
        if (new_frame) nf_cyc <= cyc;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic req();
        capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    // Camera frame: SOF, then per line one idle cycle and wb beats.
    task automatic cam_frame(input int wb, input int ln,
                             input int cap_b, input int ab_b);
        int b;
        b = 0;
        new_frame_in   = 1'b1;
        frame_valid_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        for (int l = 0; l < ln; l++) begin
            step();
            for (int c = 0; c < wb; c++) begin
                pixel_vld_in = 1'b1;
                pixel_in     = 24'($urandom);
                capture      = (b == cap_b);
                abort        = (b == ab_b);
                step();
                capture = 1'b0;
                abort   = 1'b0;
                b++;
            end
            pixel_vld_in = 1'b0;
        end
        frame_valid_in = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        sys_rst      = 1'b1;
        pixel_vld_in = 1'b1;
        step();
        step();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy got %b want 0", busy);
        end
        n_tests++;
        if (capture_end !== 1'b0) begin
            n_fail++; $display("FAIL rst_end got %b want 0", capture_end);
        end
        n_tests++;
        if (frames_done !== 8'd0) begin
            n_fail++; $display("FAIL rst_fd got %0d want 0", frames_done);
        end
        n_tests++;
        if (data_vld !== 1'b0) begin
            n_fail++; $display("FAIL rst_vld got %b want 0", data_vld);
        end
        n_tests++;
        if (new_frame !== 1'b0) begin
            n_fail++; $display("FAIL rst_nf got %b want 0", new_frame);
        end
        pixel_vld_in = 1'b0;
        sys_rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int v0, e0;
        frame_count = 8'd1;
        v0 = vld_cnt; e0 = end_cnt;
        req();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL single_busy got %b want 1", busy);
        end
        cam_frame(4, 2, -1, -1);
        n_tests++;
        if (vld_cnt - v0 !== 8) begin
            n_fail++; $display("FAIL single_beats got %0d want 8", vld_cnt - v0);
        end
        n_tests++;
        if (end_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL single_ends got %0d want 1", end_cnt - e0);
        end
        n_tests++;
        if (end_cyc - vcyc[(vld_cnt - 1) % 64] !== 1) begin
            n_fail++;
            $display("FAIL single_end_lat got %0d want 1",
                     end_cyc - vcyc[(vld_cnt - 1) % 64]);
        end
        n_tests++;
        if (frames_done !== 8'd1) begin
            n_fail++; $display("FAIL single_fd got %0d want 1", frames_done);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle got %b want 0", busy);
        end
        n_tests++;
        if (pix_err !== 0) begin
            n_fail++; $display("FAIL pix_pass got %0d errs want 0", pix_err);
        end
    endtask

    task automatic test_wait_gap();
        int v0, e0;
        frame_count = 8'd1;
        v0 = vld_cnt; e0 = end_cnt;
        cam_frame(4, 2, 1, -1);
        n_tests++;
        if (vld_cnt - v0 !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_skip got beats %0d busy %b want 0 1",
                     vld_cnt - v0, busy);
        end
        cam_frame(4, 2, -1, -1);
        n_tests++;
        if (vld_cnt - v0 !== 8 || end_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL gap_next got beats %0d ends %0d want 8 1",
                     vld_cnt - v0, end_cnt - e0);
        end
    endtask

    task automatic test_multi();
        int v0, e0;
        frame_count = 8'd3;
        v0 = vld_cnt; e0 = end_cnt;
        req();
        for (int f = 0; f < 2; f++) begin
            cam_frame(4, 2, (f == 1) ? 2 : -1, -1);
            n_tests++;
            if (busy !== 1'b1 || end_cnt - e0 !== 0) begin
                n_fail++;
                $display("FAIL multi_mid%0d got busy %b ends %0d want 1 0",
                         f, busy, end_cnt - e0);
            end
        end
        cam_frame(4, 2, -1, -1);
        n_tests++;
        if (frames_done !== 8'd3 || end_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL multi_end got fd %0d ends %0d want 3 1",
                     frames_done, end_cnt - e0);
        end
        n_tests++;
        if (vld_cnt - v0 !== 24 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_beats got %0d busy %b want 24 0",
                     vld_cnt - v0, busy);
        end
    endtask

    task automatic test_abort();
        int v0, e0;
        frame_count = 8'd1;
        v0 = vld_cnt; e0 = end_cnt;
        req();
        cam_frame(4, 2, -1, 3);
        n_tests++;
        if (vld_cnt - v0 !== 4) begin
            n_fail++; $display("FAIL abort_beats got %0d want 4", vld_cnt - v0);
        end
        n_tests++;
        if (busy !== 1'b0 || end_cnt - e0 !== 0 || frames_done !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_state got busy %b ends %0d fd %0d want 0 0 0",
                     busy, end_cnt - e0, frames_done);
        end
        v0 = vld_cnt; e0 = end_cnt;
        req();
        cam_frame(4, 2, -1, 7);
        n_tests++;
        if (vld_cnt - v0 !== 8 || end_cnt - e0 !== 0 || frames_done !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_last got beats %0d ends %0d fd %0d want 8 0 0",
                     vld_cnt - v0, end_cnt - e0, frames_done);
        end
        capture = 1'b1;
        abort   = 1'b1;
        step();
        capture = 1'b0;
        abort   = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_cap got busy %b want 0", busy);
        end
    endtask

    task automatic test_count_zero();
        int e0;
        frame_count = 8'd0;
        e0 = end_cnt;
        req();
        cam_frame(4, 2, -1, -1);
        n_tests++;
        if (frames_done !== 8'd1 || end_cnt - e0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt0 got fd %0d ends %0d busy %b want 1 1 0",
                     frames_done, end_cnt - e0, busy);
        end
    endtask

    task automatic test_truncate();
        int e0;
        frame_count = 8'd1;
        e0 = end_cnt;
        req();
        frame_valid_in = 1'b1;
        new_frame_in   = 1'b1;
        step();
        new_frame_in = 1'b0;
        pixel_vld_in = 1'b1;
        step();
        step();
        new_frame_in = 1'b1;
        step();
        new_frame_in = 1'b0;
        for (int i = 0; i < 7; i++) step();
        pixel_vld_in = 1'b0;
        step();
        n_tests++;
        if (end_cnt - e0 !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_early got ends %0d busy %b want 0 1",
                     end_cnt - e0, busy);
        end
        pixel_vld_in = 1'b1;
        step();
        pixel_vld_in = 1'b0;
        frame_valid_in = 1'b0;
        step();
        n_tests++;
        if (end_cnt - e0 !== 1 || frames_done !== 8'd1) begin
            n_fail++;
            $display("FAIL trunc_end got ends %0d fd %0d want 1 1",
                     end_cnt - e0, frames_done);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        frame_count = 8'd2;
        e0 = end_cnt;
        req();
        frame_valid_in = 1'b1;
        new_frame_in   = 1'b1;
        step();
        new_frame_in = 1'b0;
        pixel_vld_in = 1'b1;
        step();
        step();
        sys_rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || data_vld !== 1'b0 || frames_done !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid got busy %b vld %b fd %0d want 0 0 0",
                     busy, data_vld, frames_done);
        end
        step();
        sys_rst = 1'b0;
        pixel_vld_in = 1'b0;
        frame_valid_in = 1'b0;
        step();
        step();
        n_tests++;
        if (end_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL rstmid_end got %0d want 0", end_cnt - e0);
        end
    endtask

`ifdef CAM_TEST_PATTERN_EN
    task automatic test_pattern();
        int v0, e0, k;
        logic [23:0] exp_pix [4];
        exp_pix[0] = 24'h001000;
        exp_pix[1] = 24'h003002;
        exp_pix[2] = 24'h002001;
        exp_pix[3] = 24'h004003;
        image_width = 16'd4;
        frame_count = 8'd1;
        test_mode   = 1'b1;
        v0 = vld_cnt; e0 = end_cnt;
        req();
        k = 0;
        while (end_cnt == e0 && k < 100) begin
            step();
            k++;
        end
        n_tests++;
        if (end_cnt - e0 !== 1 || vld_cnt - v0 !== 4) begin
            n_fail++;
            $display("FAIL tp_done got ends %0d beats %0d want 1 4",
                     end_cnt - e0, vld_cnt - v0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (vpix[(v0 + i) % 64] !== exp_pix[i]) begin
                    n_fail++;
                    $display("FAIL tp_pix%0d got %h want %h", i,
                             vpix[(v0 + i) % 64], exp_pix[i]);
                end
            end
            n_tests++;
            if (vcyc[v0 % 64] - nf_cyc !== 5
                || vcyc[(v0 + 2) % 64] - vcyc[(v0 + 1) % 64] !== 5
                || vcyc[(v0 + 1) % 64] - vcyc[v0 % 64] !== 1) begin
                n_fail++;
                $display("FAIL tp_gap got %0d %0d %0d want 5 1 5",
                         vcyc[v0 % 64] - nf_cyc,
                         vcyc[(v0 + 1) % 64] - vcyc[v0 % 64],
                         vcyc[(v0 + 2) % 64] - vcyc[(v0 + 1) % 64]);
            end
            n_tests++;
            if (end_cyc - vcyc[(v0 + 3) % 64] !== 1) begin
                n_fail++;
                $display("FAIL tp_end got %0d want 1",
                         end_cyc - vcyc[(v0 + 3) % 64]);
            end
        end
        test_mode   = 1'b0;
        image_width = 16'd8;
        step();
    endtask
`else
    task automatic test_pattern();
        int v0, e0;
        frame_count = 8'd1;
        test_mode   = 1'b1;
        v0 = vld_cnt; e0 = end_cnt;
        req();
        cam_frame(4, 2, -1, -1);
        n_tests++;
        if (vld_cnt - v0 !== 8 || end_cnt - e0 !== 1) begin
            n_fail++;
            $display("FAIL tm_ignored got beats %0d ends %0d want 8 1",
                     vld_cnt - v0, end_cnt - e0);
        end
        test_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wait_gap();
        test_multi();
        test_abort();
        test_count_zero();
        test_truncate();
        test_reset_mid();
        test_pattern();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
